csa_accum_ctrl: RTL

Sequential multi-operand accumulator controller built around one internal csaRow instance.
- Folds a stream of WIDTH-bit operands into redundant sum/carry registers, one operand per cycle, with no carry propagation in the loop.
- On the operand flagged last, runs one carry-propagate resolve cycle and presents the result on a valid/ready output.
- Front end for the multi-operand adders and multiplier partial-product accumulation in the arithmetic components.

---
 rtl/csa_accum_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: folds one operand per cycle into redundant sum/carry
// registers, then resolves with a single carry-propagate add and hands off the result.

module csa_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] ci,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] co
);
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign s[gi]  = a[gi] ^ b[gi] ^ ci[gi];
      assign co[gi] = (a[gi] & b[gi]) | (a[gi] & ci[gi]) | (b[gi] & ci[gi]);
    end
  endgenerate
endmodule

module csa_accum_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);
  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] RESOLVE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] car_reg;
  logic [WIDTH-1:0] res_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] car_shift;
  logic [WIDTH-1:0] csa_s;
  logic [WIDTH-1:0] csa_co;
  logic             car_msb_unused;
  logic             accept;

  // Carries weigh one bit higher; the top carry falls off, giving modulo 2^WIDTH.
  assign car_shift      = {car_reg[WIDTH-2:0], 1'b0};
  assign car_msb_unused = car_reg[WIDTH-1];

  csa_row #(.WIDTH(WIDTH)) u_csa_row (
    .a  (sum_reg),
    .b  (car_shift),
    .ci (in_data),
    .s  (csa_s),
    .co (csa_co)
  );

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid & in_ready;

  // Outputs come straight from registers, masked to zero outside DONE.
  assign out_data  = (state_reg == DONE) ? res_reg : '0;
  assign out_count = (state_reg == DONE) ? cnt_reg : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      sum_reg   <= '0;
      car_reg   <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
    end else if (clr) begin
      state_reg <= ACCUM;
      sum_reg   <= '0;
      car_reg   <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            sum_reg <= csa_s;
            car_reg <= csa_co;
            if (cnt_reg != {CNT_W{1'b1}}) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
            if (in_last) begin
              state_reg <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          res_reg   <= sum_reg + car_shift;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            sum_reg   <= '0;
            car_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ACCUM;
          end
        end
        default: begin
          state_reg <= ACCUM;
        end
      endcase
    end
  end
endmodule
